// File: rtl/arbiter_4.sv
// arbiter_4: 4-way round-robin arbiter with hold-time limit and forced release under contention
module arbiter_4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d, idx_d, off, sel;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_d, rot;
  logic [6:0] dbl;
  logic       preempt_d, contend;
  // rot[k] is the request of (ptr+k) mod 4, so the lowest set bit is the winner
  assign dbl       = {req[2:0], req};
  assign rot       = dbl[ptr_q +: 4];
  assign off       = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
  assign sel       = ptr_q + off;
  assign contend   = |(req & ~gnt);
  assign gnt_valid = (state_q == BUSY);
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    idx_d     = gnt_idx;
    gnt_d     = gnt;
    preempt_d = 1'b0;
    if (state_q == IDLE) begin
      if (|req) begin
        state_d = BUSY;
        idx_d   = sel;
        gnt_d   = 4'b0001 << sel;
        hold_d  = 8'd0;
      end
    end else if (!req[gnt_idx] || (hold_q == HOLD_LAST && contend)) begin
      state_d   = IDLE;
      ptr_d     = gnt_idx + 2'd1;
      idx_d     = 2'd0;
      gnt_d     = 4'b0000;
      preempt_d = req[gnt_idx];
    end else begin
      hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= 8'd0;
      gnt     <= 4'b0000;
      gnt_idx <= 2'd0;
      preempt <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt     <= gnt_d;
      gnt_idx <= idx_d;
      preempt <= preempt_d;
    end
  end
endmodule

// File: tb/tb_arbiter_4.sv
// tb_arbiter_4: directed scoreboard bench for arbiter_4 with HOLD_MAX=8
module tb_arbiter_4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid, preempt;
  int         total = 0, bad = 0;
  logic [7:0] sb[$];
  arbiter_4 #(.HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] pack(input logic [3:0] g, input logic p);
    logic [1:0] i;
    i = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    return {g, i, |g, p};
  endfunction
  task automatic check(input string tag);
    logic [7:0] obs, exp;
    obs = {gnt, gnt_idx, gnt_valid, preempt};
    exp = sb.pop_front();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] eg, input logic ep);
    req = r;
    @(posedge clk);
    sb.push_back(pack(eg, ep));
    #1 check(tag);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    #1 sb.push_back(pack(4'b0000, 1'b0));
    check("reset");
    @(negedge clk) rst = 1'b0;
  endtask
  initial begin
    #12 sb.push_back(pack(4'b0000, 1'b0));
    check("reset_init");
    @(negedge clk) rst = 1'b0;
    cyc("idle_none", 4'b0000, 4'b0000, 1'b0);
    cyc("first_grant", 4'b1010, 4'b0010, 1'b0);
    cyc("drop_release", 4'b1000, 4'b0000, 1'b0);
    cyc("grant3", 4'b1000, 4'b1000, 1'b0);
    cyc("drop3", 4'b0000, 4'b0000, 1'b0);
    cyc("ptr_wrap", 4'b1111, 4'b0001, 1'b0);
    cyc("drop0", 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) cyc("alone", 4'b0100, 4'b0100, 1'b0);
    cyc("sat_contend", 4'b0101, 4'b0000, 1'b1);
    cyc("after_force", 4'b0000, 4'b0000, 1'b0);
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 8; i++) cyc("hold", 4'b0011, p[0] ? 4'b0010 : 4'b0001, 1'b0);
      cyc("force", 4'b0011, 4'b0000, 1'b1);
    end
    cyc("idle_rest", 4'b0000, 4'b0000, 1'b0);
    cyc("own0", 4'b0001, 4'b0001, 1'b0);
    for (int i = 0; i < 7; i++) cyc("own0_contend", 4'b0101, 4'b0001, 1'b0);
    cyc("drop_beats_force", 4'b0100, 4'b0000, 1'b0);
    cyc("grant2", 4'b0100, 4'b0100, 1'b0);
    #2 rst = 1'b1;
    #1 sb.push_back(pack(4'b0000, 1'b0));
    check("async_rst");
    @(negedge clk) rst = 1'b0;
    cyc("post_rst", 4'b1111, 4'b0001, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
